// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch stage and F->D pipeline register
// Owns the PC, applies stall/redirect, kills wrong-path fetches and decodes D-stage fields.
module fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        next_pc_sel,
    input  logic [31:0] jb_pc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] D_pc,
    output logic [31:0] D_inst,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic        func7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] D_imm,
    output logic [31:0] fetch_cnt
);

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    logic [31:0] f_pc;
    logic        d_kill;
    logic        hold_valid;
    logic [31:0] hold_inst;

    // Redirect outranks stall so a taken branch is never lost behind a load-use hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_pc       <= PC_RESET;
            D_pc       <= 32'h0;
            d_kill     <= 1'b1;
            hold_valid <= 1'b0;
            hold_inst  <= 32'h0;
            fetch_cnt  <= 32'h0;
        end else if (!next_pc_sel) begin
            f_pc       <= jb_pc & ~32'h1;
            D_pc       <= f_pc;
            d_kill     <= 1'b1;
            hold_valid <= 1'b0;
        end else if (stall) begin
            // Memory keeps reading F_pc, so the D instruction must be captured once.
            if (!hold_valid) begin
                hold_inst  <= im_rdata;
                hold_valid <= 1'b1;
            end
        end else begin
            f_pc       <= f_pc + 32'd4;
            D_pc       <= f_pc;
            d_kill     <= 1'b0;
            hold_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
        end
    end

    assign im_addr = f_pc;
    assign D_inst  = d_kill ? NOP_INST : (hold_valid ? hold_inst : im_rdata);
    assign opcode  = D_inst[6:2];
    assign func3   = D_inst[14:12];
    assign func7   = D_inst[30];
    assign rd      = D_inst[11:7];
    assign rs1     = D_inst[19:15];
    assign rs2     = D_inst[24:20];

    always_comb begin
        D_imm = 32'h0;
        case (opcode)
            OP_LOAD, OP_IMM, OP_JALR:
                D_imm = {{20{D_inst[31]}}, D_inst[31:20]};
            OP_STORE:
                D_imm = {{20{D_inst[31]}}, D_inst[31:25], D_inst[11:7]};
            OP_BRANCH:
                D_imm = {{19{D_inst[31]}}, D_inst[31], D_inst[7], D_inst[30:25],
                         D_inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                D_imm = {D_inst[31:12], 12'b0};
            OP_JAL:
                D_imm = {{11{D_inst[31]}}, D_inst[31], D_inst[19:12], D_inst[20],
                         D_inst[30:21], 1'b0};
            default:
                D_imm = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        next_pc_sel;
    logic [31:0] jb_pc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata = 32'h0;
    logic [31:0] D_pc;
    logic [31:0] D_inst;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] D_imm;
    logic [31:0] fetch_cnt;

    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .next_pc_sel(next_pc_sel), .jb_pc(jb_pc),
        .im_addr(im_addr), .im_rdata(im_rdata), .D_pc(D_pc), .D_inst(D_inst),
        .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
        .D_imm(D_imm), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) im_rdata <= mem[im_addr[11:2]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = (i << 20) | 32'h0000_0033;
        mem[0] = 32'h0050_0093;
        mem[1] = 32'h0010_0113;
        mem[2] = 32'hFE00_08E3;
        mem[3] = 32'h8000_006F;

        rst = 1'b1; stall = 1'b0; next_pc_sel = 1'b1; jb_pc = 32'h0;
        step(); step();
        check("rst_inst", D_inst, NOP);
        check("rst_opcode", {27'h0, opcode}, 32'h4);
        check("rst_rd", {27'h0, rd}, 32'h0);
        check("rst_imm", D_imm, 32'h0);
        check("rst_cnt", fetch_cnt, 32'h0);
        check("rst_addr", im_addr, 32'h0);
        check("rst_dpc", D_pc, 32'h0);
        rst = 1'b0;
        #2;
        check("c1_inst", D_inst, NOP);

        // straight-line fetch
        step();
        check("e1_dpc", D_pc, 32'h0);
        check("e1_inst", D_inst, 32'h0050_0093);
        check("e1_rd", {27'h0, rd}, 32'h1);
        check("e1_imm", D_imm, 32'h5);
        check("e1_addr", im_addr, 32'h4);
        check("e1_cnt", fetch_cnt, 32'h1);
        step();
        check("e2_dpc", D_pc, 32'h4);
        check("e2_inst", D_inst, mem[1]);
        check("e2_rd", {27'h0, rd}, 32'h2);
        step();
        check("e3_dpc", D_pc, 32'h8);
        check("beq_opcode", {27'h0, opcode}, 32'h18);
        check("beq_imm", D_imm, 32'hFFFF_FFF0);
        step();
        check("e4_dpc", D_pc, 32'hC);
        check("jal_imm", D_imm, 32'hFFF0_0000);
        check("e4_cnt", fetch_cnt, 32'h4);
        check("e4_addr", im_addr, 32'h10);

        // redirect to odd target: bit 0 cleared, one bubble
        next_pc_sel = 1'b0; jb_pc = 32'h41;
        step();
        check("rd_addr", im_addr, 32'h40);
        check("rd_inst", D_inst, NOP);
        check("rd_dpc", D_pc, 32'h10);
        check("rd_cnt", fetch_cnt, 32'h4);
        next_pc_sel = 1'b1;
        step();
        check("rd1_dpc", D_pc, 32'h40);
        check("rd1_inst", D_inst, mem[16]);
        check("rd1_cnt", fetch_cnt, 32'h5);

        // back to 0, advance to D_pc=8, then stall 3 cycles
        next_pc_sel = 1'b0; jb_pc = 32'h0;
        step();
        check("rd0_inst", D_inst, NOP);
        next_pc_sel = 1'b1;
        step(); step(); step();
        check("pre_st_dpc", D_pc, 32'h8);
        check("pre_st_cnt", fetch_cnt, 32'h8);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_dpc", D_pc, 32'h8);
            check("st_inst", D_inst, mem[2]);
            check("st_addr", im_addr, 32'hC);
            check("st_cnt", fetch_cnt, 32'h8);
        end
        stall = 1'b0;
        step();
        check("post_st_dpc", D_pc, 32'hC);
        check("post_st_inst", D_inst, mem[3]);
        check("post_st_cnt", fetch_cnt, 32'h9);

        // stall one cycle (hold armed), then coincident stall + redirect
        stall = 1'b1;
        step();
        check("st2_inst", D_inst, mem[3]);
        next_pc_sel = 1'b0; jb_pc = 32'h100;
        step();
        check("sr_addr", im_addr, 32'h100);
        check("sr_dpc", D_pc, 32'h10);
        check("sr_inst", D_inst, NOP);
        check("sr_cnt", fetch_cnt, 32'h9);
        stall = 1'b0; next_pc_sel = 1'b1;
        step();
        check("sr1_dpc", D_pc, 32'h100);
        check("sr1_inst", D_inst, mem[64]);
        check("sr1_cnt", fetch_cnt, 32'hA);

        // PC wrap at 2^32
        next_pc_sel = 1'b0; jb_pc = 32'hFFFF_FFFD;
        step();
        check("wr_addr", im_addr, 32'hFFFF_FFFC);
        next_pc_sel = 1'b1;
        step();
        check("wr1_addr", im_addr, 32'h0);
        check("wr1_dpc", D_pc, 32'hFFFF_FFFC);
        check("wr1_inst", D_inst, mem[1023]);

        // async reset in the middle of a stall
        stall = 1'b1;
        step();
        rst = 1'b1;
        #1;
        check("ars_inst", D_inst, NOP);
        check("ars_dpc", D_pc, 32'h0);
        check("ars_cnt", fetch_cnt, 32'h0);
        check("ars_addr", im_addr, 32'h0);
        step();
        rst = 1'b0; stall = 1'b0;
        step();
        check("ars1_dpc", D_pc, 32'h0);
        check("ars1_inst", D_inst, mem[0]);
        check("ars1_cnt", fetch_cnt, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
